cpu_c1_master: RTL and testbench

- CPU-side bus master for the L1 cache subsystem.
- Accepts single load/store requests from a local request port and serialises each one onto the two-phase C1 cache bus. It then waits for the cache response and returns the read data.
- Keeps running hit/miss statistics and a free-running cycle counter, which is the synthesizable equivalent of the simulation clock's `timing` output.
- Sits between the workload driver (CPU model) and the LRU cache.

---
 rtl/cpu_c1_master_pkg.sv | 17 +
 rtl/cpu_c1_master_if.sv | 26 ++
 rtl/cpu_c1_master_stat_counters.sv | 29 ++
 rtl/cpu_c1_master.sv | 106 ++++++++++
 tb/tb_cpu_c1_master.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/cpu_c1_master_pkg.sv
// c1_pkg: C1 bus command codes, cache geometry and master FSM states.
package c1_pkg;
  localparam int ADDR_W = 19;
  localparam int OFFSET_W = 4;
  localparam int A1_W = 15;
  localparam int D1_W = 16;
  localparam int CACHE_LINE = 16;
  localparam int CACHE_WAY = 2;
  localparam int CACHE_SETS = 32;
  typedef enum logic [2:0] {
    NOP = 3'd0, READ8 = 3'd1, READ16 = 3'd2, READ32 = 3'd3,
    INV_LINE = 3'd4, WRITE8 = 3'd5, WRITE16 = 3'd6, WRITE32 = 3'd7
  } cmd_e;
  // RESPONSE shares its code with WRITE32, so it cannot live in the enum
  localparam logic [2:0] RESPONSE = 3'd7;
  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, RECV1, RECV2} state_e;
endpackage

// File: rtl/cpu_c1_master_if.sv
// cpu_c1_master_if: request/response port and C1 cache bus of the CPU-side master.
interface cpu_c1_master_if;
  import c1_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [2:0]        c1_out;
  logic [A1_W-1:0]   a1_out;
  logic [D1_W-1:0]   d1_out;
  logic              bus_oe;
  logic [2:0]        c1_in;
  logic [D1_W-1:0]   d1_in;
  logic              hit_in;
  modport master (
    input  req_valid, req_cmd, req_addr, req_wdata, c1_in, d1_in, hit_in,
    output req_ready, rsp_valid, rsp_rdata, c1_out, a1_out, d1_out, bus_oe
  );
  modport slave (
    output req_valid, req_cmd, req_addr, req_wdata, c1_in, d1_in, hit_in,
    input  req_ready, rsp_valid, rsp_rdata, c1_out, a1_out, d1_out, bus_oe
  );
endinterface

// File: rtl/cpu_c1_master_stat_counters.sv
// stat_counters: wrapping hit/miss counters plus a free-running cycle counter.
module stat_counters #(
  parameter int CNT_W  = 32,
  parameter int TIME_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hit,
  input  logic              i_miss,
  output logic [CNT_W-1:0]  o_hits,
  output logic [CNT_W-1:0]  o_misses,
  output logic [TIME_W-1:0] o_cycles
);
  logic [CNT_W-1:0]  r_hits, r_misses;
  logic [TIME_W-1:0] r_cycles;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_cycles <= '0;
    end else begin
      r_hits   <= r_hits + CNT_W'(i_hit);
      r_misses <= r_misses + CNT_W'(i_miss);
      r_cycles <= r_cycles + TIME_W'(1);
    end
  assign o_hits   = r_hits;
  assign o_misses = r_misses;
  assign o_cycles = r_cycles;
endmodule

// File: rtl/cpu_c1_master.sv
// cpu_c1_master: serialises one load/store at a time onto the two-phase C1 bus
// and returns read data; bus outputs are registered from the next state.
module cpu_c1_master
  import c1_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int TIME_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  cpu_c1_master_if.master     bus,
  output logic [CNT_W-1:0]    total_hits,
  output logic [CNT_W-1:0]    total_misses,
  output logic [TIME_W-1:0]   cycle_count
);
  state_e                r_state, w_nxt;
  cmd_e                  r_cmd;
  logic [OFFSET_W-1:0]   r_off;
  logic [15:0]           r_whi;
  logic [31:0]           r_rdata, w_rdata;
  logic                  r_rsp_valid, r_bus_oe;
  logic [2:0]            r_c1;
  logic [A1_W-1:0]       r_a1;
  logic [D1_W-1:0]       r_d1;
  logic                  w_accept, w_rsp_seen, w_done, w_send1, w_send2;
  assign w_accept   = bus.req_valid && r_state == IDLE;
  assign w_rsp_seen = r_state == WAIT && bus.c1_in == RESPONSE;
  assign w_send1    = w_nxt == SEND1;
  assign w_send2    = w_nxt == SEND2;
  // RECV1 is the WAIT cycle that samples RESPONSE; only READ32 needs a second beat
  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) begin
        if (bus.req_cmd == NOP) w_done = 1'b1;
        else w_nxt = SEND1;
      end
      SEND1: w_nxt = SEND2;
      SEND2: w_nxt = WAIT;
      WAIT:  if (w_rsp_seen) begin
        if (r_cmd == READ32) w_nxt = RECV2;
        else begin
          w_nxt  = IDLE;
          w_done = 1'b1;
        end
      end
      RECV2: begin
        w_nxt  = IDLE;
        w_done = 1'b1;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_rdata = r_rdata;
    if (w_accept) w_rdata = '0;
    if (w_rsp_seen)
      w_rdata = r_cmd == READ8 ? {24'd0, bus.d1_in[7:0]} :
                (r_cmd == READ16 || r_cmd == READ32) ? {16'd0, bus.d1_in} : '0;
    if (r_state == RECV2) w_rdata = {bus.d1_in, r_rdata[15:0]};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= IDLE;
      r_cmd       <= NOP;
      r_off       <= '0;
      r_whi       <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_c1        <= '0;
      r_a1        <= '0;
      r_d1        <= '0;
    end else begin
      r_state     <= w_nxt;
      r_rsp_valid <= w_done;
      r_rdata     <= w_rdata;
      if (w_accept) begin
        r_cmd <= cmd_e'(bus.req_cmd);
        r_off <= bus.req_addr[OFFSET_W-1:0];
        r_whi <= bus.req_wdata[31:16];
      end
      r_bus_oe <= w_send1 || w_send2;
      r_c1     <= w_send1 ? bus.req_cmd : w_send2 ? r_cmd : NOP;
      r_a1     <= w_send1 ? bus.req_addr[ADDR_W-1:OFFSET_W] :
                  w_send2 ? A1_W'(r_off) : '0;
      r_d1     <= w_send1 ? bus.req_wdata[15:0] : w_send2 ? r_whi : '0;
    end
  assign bus.req_ready = r_state == IDLE;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.bus_oe    = r_bus_oe;
  assign bus.c1_out    = r_c1;
  assign bus.a1_out    = r_a1;
  assign bus.d1_out    = r_d1;
  stat_counters #(.CNT_W(CNT_W), .TIME_W(TIME_W)) u_stats (
    .clk      (clk),
    .rst_n    (reset),
    .i_hit    (w_rsp_seen && bus.hit_in),
    .i_miss   (w_rsp_seen && !bus.hit_in),
    .o_hits   (total_hits),
    .o_misses (total_misses),
    .o_cycles (cycle_count)
  );
endmodule

// File: tb/tb_cpu_c1_master.sv
// tb_cpu_c1_master: directed transactions with hand-computed bus phases, data and counters.
module tb_cpu_c1_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hits, misses;
  logic [63:0] cycles, c0;
  int          n_chk = 0, n_err = 0;
  cpu_c1_master_if bus_if ();
  cpu_c1_master dut (
    .clk          (clk),
    .reset        (rst_n),
    .bus          (bus_if),
    .total_hits   (hits),
    .total_misses (misses),
    .cycle_count  (cycles)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic txn(input logic [2:0] cmd, input logic [18:0] a, input logic [31:0] wd,
                     input int wt, input logic [15:0] da, input logic [15:0] db,
                     input logic h, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    logic [14:0] a_hi;
    logic [3:0]  a_lo;
    a_hi = a[18:4];
    a_lo = a[3:0];
    bus_if.req_valid = 1'b1;
    bus_if.req_cmd   = cmd;
    bus_if.req_addr  = a;
    bus_if.req_wdata = wd;
    step();
    bus_if.req_valid = 1'b0;
    lat = 0;
    if (cmd != 3'd0) begin
      check("s1_oe", bus_if.bus_oe, 1);
      check("s1_c1", bus_if.c1_out, cmd);
      check("s1_a1", bus_if.a1_out, a_hi);
      check("s1_d1", bus_if.d1_out, wd[15:0]);
      step(); lat++;
      check("s2_oe", bus_if.bus_oe, 1);
      check("s2_c1", bus_if.c1_out, cmd);
      check("s2_a1", bus_if.a1_out, {11'd0, a_lo});
      check("s2_d1", bus_if.d1_out, wd[31:16]);
      step(); lat++;
      check("w_oe", bus_if.bus_oe, 0);
      check("w_c1", bus_if.c1_out, 0);
      repeat (wt) begin step(); lat++; end
      bus_if.c1_in  = 3'd7;
      bus_if.d1_in  = da;
      bus_if.hit_in = h;
      step(); lat++;
      bus_if.c1_in  = 3'd0;
      bus_if.d1_in  = db;
      bus_if.hit_in = 1'b0;
      if (cmd == 3'd3) begin
        check("r2_vld", bus_if.rsp_valid, 0);
        check("r2_oe", bus_if.bus_oe, 0);
        step(); lat++;
      end
      bus_if.d1_in = '0;
    end
    check("rsp_vld", bus_if.rsp_valid, 1);
    check("rsp_data", bus_if.rsp_rdata, exp_rd);
    check("rsp_lat", lat, exp_lat);
    check("rsp_rdy", bus_if.req_ready, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_cmd   = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.c1_in     = '0;
    bus_if.d1_in     = '0;
    bus_if.hit_in    = 1'b0;
    repeat (3) step();
    check("rst_oe", bus_if.bus_oe, 0);
    check("rst_vld", bus_if.rsp_valid, 0);
    check("rst_rd", bus_if.rsp_rdata, 0);
    check("rst_c1", bus_if.c1_out, 0);
    check("rst_a1", bus_if.a1_out, 0);
    check("rst_hits", hits, 0);
    check("rst_miss", misses, 0);
    check("rst_cyc", cycles, 0);
    check("rst_rdy", bus_if.req_ready, 1);
    rst_n = 1'b1;
    step();
    check("cyc_first", cycles, 1);
    bus_if.req_valid = 1'b1;
    bus_if.req_cmd   = 3'd2;
    bus_if.req_addr  = 19'h12345;
    step();
    bus_if.req_valid = 1'b0;
    check("mr_s1_a1", bus_if.a1_out, 15'h1234);
    step();
    check("mr_s2_a1", bus_if.a1_out, 15'h0005);
    step();
    check("mr_w_rdy", bus_if.req_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mr_oe", bus_if.bus_oe, 0);
    check("mr_rdy", bus_if.req_ready, 1);
    check("mr_cyc", cycles, 0);
    bus_if.c1_in  = 3'd7;
    bus_if.hit_in = 1'b1;
    step();
    check("mr_vld", bus_if.rsp_valid, 0);
    check("mr_hits", hits, 0);
    bus_if.c1_in  = 3'd0;
    bus_if.hit_in = 1'b0;
    rst_n = 1'b1;
    step();
    check("mr_vld2", bus_if.rsp_valid, 0);
    check("mr_miss", misses, 0);
    txn(3'd1, 19'h00A35, 32'h0, 5, 16'hBEEF, 16'h0, 1'b1, 32'h000000EF, 8);
    check("r8_hits", hits, 1);
    check("r8_miss", misses, 0);
    txn(3'd3, 19'h7FFFC, 32'h0, 2, 16'h5678, 16'h1234, 1'b0, 32'h12345678, 6);
    check("r32_miss", misses, 1);
    txn(3'd7, 19'h01000, 32'hDEADBEEF, 0, 16'h0, 16'h0, 1'b0, 32'h0, 3);
    check("w32_miss", misses, 2);
    txn(3'd0, 19'h0, 32'h0, 0, 16'h0, 16'h0, 1'b0, 32'h0, 0);
    check("nop_hits", hits, 1);
    check("nop_miss", misses, 2);
    txn(3'd2, 19'h0ABC7, 32'h0, 1, 16'hBEEF, 16'h0, 1'b1, 32'h0000BEEF, 4);
    check("r16_hits", hits, 2);
    step();
    check("vld_pulse", bus_if.rsp_valid, 0);
    bus_if.c1_in  = 3'd7;
    bus_if.hit_in = 1'b1;
    bus_if.d1_in  = 16'hFFFF;
    repeat (3) step();
    check("sp_hits", hits, 2);
    check("sp_miss", misses, 2);
    check("sp_vld", bus_if.rsp_valid, 0);
    check("sp_oe", bus_if.bus_oe, 0);
    bus_if.c1_in  = 3'd0;
    bus_if.hit_in = 1'b0;
    bus_if.d1_in  = '0;
    c0 = cycles;
    repeat (10) step();
    check("cyc_delta", cycles - c0, 10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
